// File: rtl/vector_gather_pkg.sv
// Shared defaults and helpers for the vector_gather block.
//   DEF_*       : default channel count, index/value widths, output FIFO depth
//   occ_width() : width needed to hold an occupancy of 0..depth inclusive
package vector_gather_pkg;

   localparam int DEF_CHANNELS  = 4;
   localparam int DEF_ID_WIDTH  = 10;
   localparam int DEF_VAL_WIDTH = 8;
   localparam int DEF_OUT_DEPTH = 4;

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/vector_gather_if.sv
// Bundle of all vector_gather data/handshake signals.
//   id/id_empty/id_read       : upstream FWFT id FIFOs, one per channel
//   val/val_empty/val_read    : downstream FWFT value FIFOs, one per channel
//   vec_load/vec_wr_*         : run-time vector memory load port
//   fetch_count               : total ids consumed since reset
// master = environment side, slave = vector_gather side.
interface vector_gather_if import vector_gather_pkg::*; #(
   parameter int CHANNELS  = DEF_CHANNELS,
   parameter int ID_WIDTH  = DEF_ID_WIDTH,
   parameter int VAL_WIDTH = DEF_VAL_WIDTH
) ();

   logic [CHANNELS-1:0][ID_WIDTH-1:0]  id;
   logic [CHANNELS-1:0]                id_empty;
   logic [CHANNELS-1:0]                id_read;
   logic [CHANNELS-1:0][VAL_WIDTH-1:0] val;
   logic [CHANNELS-1:0]                val_empty;
   logic [CHANNELS-1:0]                val_read;
   logic                               vec_load;
   logic                               vec_wr_en;
   logic [ID_WIDTH-1:0]                vec_wr_addr;
   logic [VAL_WIDTH-1:0]               vec_wr_data;
   logic [31:0]                        fetch_count;

   modport master (
      output id, id_empty, val_read, vec_load, vec_wr_en, vec_wr_addr, vec_wr_data,
      input  id_read, val, val_empty, fetch_count
   );

   modport slave (
      input  id, id_empty, val_read, vec_load, vec_wr_en, vec_wr_addr, vec_wr_data,
      output id_read, val, val_empty, fetch_count
   );

endinterface

// File: rtl/gather_out_fifo.sv
// Per-channel first-word-fall-through output FIFO.
//   clk, rst : clock, synchronous active-high reset
//   i_push   : write i_data (ignored when full)
//   i_pop    : drop the head (ignored when empty)
//   o_data   : head value while non-empty, 0 when empty
//   o_empty  : FIFO empty
//   o_occ    : current occupancy, 0..OUT_DEPTH
module gather_out_fifo import vector_gather_pkg::*; #(
   parameter int VAL_WIDTH = DEF_VAL_WIDTH,
   parameter int OUT_DEPTH = DEF_OUT_DEPTH,
   localparam int OCC_W    = occ_width(OUT_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_push,
   input  logic [VAL_WIDTH-1:0] i_data,
   input  logic                 i_pop,
   output logic [VAL_WIDTH-1:0] o_data,
   output logic                 o_empty,
   output logic [OCC_W-1:0]     o_occ
);

   localparam int AW = $clog2(OUT_DEPTH);

   logic [VAL_WIDTH-1:0] r_mem [OUT_DEPTH];
   logic [AW-1:0]        r_wp;
   logic [AW-1:0]        r_rp;
   logic [OCC_W-1:0]     r_occ;
   logic                 w_push;
   logic                 w_pop;

   assign w_push = i_push && (r_occ != OCC_W'(OUT_DEPTH));
   assign w_pop  = i_pop  && (r_occ != '0);

   // storage is not reset; emptiness is tracked by r_occ alone
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_occ <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_empty = (r_occ == '0);
   assign o_data  = o_empty ? '0 : r_mem[r_rp];
   assign o_occ   = r_occ;

endmodule

// File: rtl/vector_gather.sv
// Multi-channel vector gather: each channel pops column ids from its
// upstream FWFT FIFO, reads the dense-vector entry and queues the value
// in its own output FIFO. Issue is credit based (output occupancy plus
// the one read in flight), so values are never dropped.
//   clk, rst : clock, synchronous active-high reset
//   bus      : vector_gather_if slave (id/val FIFO ports, vector load
//              port, fetch_count)
module vector_gather import vector_gather_pkg::*; #(
   parameter int CHANNELS  = DEF_CHANNELS,
   parameter int ID_WIDTH  = DEF_ID_WIDTH,
   parameter int VAL_WIDTH = DEF_VAL_WIDTH,
   parameter int OUT_DEPTH = DEF_OUT_DEPTH
) (
   input logic            clk,
   input logic            rst,
   vector_gather_if.slave bus
);

   localparam int OCC_W = occ_width(OUT_DEPTH);

   logic [VAL_WIDTH-1:0]               r_mem [2**ID_WIDTH];
   logic [CHANNELS-1:0][VAL_WIDTH-1:0] r_rd_data;
   logic [CHANNELS-1:0]                r_inflight;
   logic [31:0]                        r_fetch_count;

   logic [CHANNELS-1:0][OCC_W-1:0]     w_occ;
   logic [CHANNELS-1:0][VAL_WIDTH-1:0] w_val;
   logic [CHANNELS-1:0]                w_val_empty;
   logic [CHANNELS-1:0]                w_issue;
   logic [31:0]                        w_pop_cnt;

   // Vector memory: written regardless of vec_load, never reset. The
   // nonblocking write makes same-cycle reads return the old data.
   always_ff @(posedge clk) begin
      if (bus.vec_wr_en) r_mem[bus.vec_wr_addr] <= bus.vec_wr_data;
   end

   // Credit check uses registered state only, so a pop this cycle frees
   // its slot for issue on the following cycle.
   always_comb begin
      w_issue = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_issue[c] = !rst && !bus.vec_load && !bus.id_empty[c] &&
                      (({1'b0, w_occ[c]} + (OCC_W+1)'(r_inflight[c])) <
                       (OCC_W+1)'(OUT_DEPTH));
      end
   end

   always_comb begin
      w_pop_cnt = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_pop_cnt = w_pop_cnt + 32'(w_issue[c]);
      end
   end

   // Read stage: one registered read per channel; r_inflight marks a value
   // that lands in the output FIFO at the next edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight    <= '0;
         r_rd_data     <= '0;
         r_fetch_count <= '0;
      end else begin
         r_inflight    <= w_issue;
         r_fetch_count <= r_fetch_count + w_pop_cnt;
         for (int c = 0; c < CHANNELS; c++) begin
            if (w_issue[c]) r_rd_data[c] <= r_mem[bus.id[c]];
         end
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      gather_out_fifo #(
         .VAL_WIDTH (VAL_WIDTH),
         .OUT_DEPTH (OUT_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .i_push  (r_inflight[c]),
         .i_data  (r_rd_data[c]),
         .i_pop   (bus.val_read[c]),
         .o_data  (w_val[c]),
         .o_empty (w_val_empty[c]),
         .o_occ   (w_occ[c])
      );
   end

   assign bus.id_read     = w_issue;
   assign bus.val         = w_val;
   assign bus.val_empty   = w_val_empty;
   assign bus.fetch_count = r_fetch_count;

endmodule

// File: doc/vector_gather.md
Name: vector_gather

Overview:
- Parametrised successor to the fixed 4-channel value fetch block in the sparse accelerator.
- Each channel pops column indices from an upstream first-word-fall-through (FWFT) id FIFO and reads the corresponding dense-vector entry from an on-chip vector memory. The value is pushed into a per-channel output FIFO.
- New versus the previous generation:
  - channel count, index width, value width and output depth are generic;
  - the vector is loadable at run time;
  - output issue is credit-based, so no value is ever dropped;
  - a fetch counter is exposed.

Parameters:
- CHANNELS, 4, number of independent fetch lanes
- ID_WIDTH, 10, index width; vector memory depth = 2**ID_WIDTH
- VAL_WIDTH, 8, vector element width
- OUT_DEPTH, 4, per-channel output FIFO depth; power of 2, at least 2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id  in  CHANNELS*ID_WIDTH  per-channel FWFT id heads; channel c occupies [c*ID_WIDTH +: ID_WIDTH]
- id_empty  in  CHANNELS  per-channel upstream FIFO empty
- id_read  out  CHANNELS  per-channel upstream pop strobe
- val  out  CHANNELS*VAL_WIDTH  per-channel output FIFO head (FWFT)
- val_empty  out  CHANNELS  per-channel output FIFO empty
- val_read  in  CHANNELS  per-channel downstream pop
- vec_load  in  1  load mode; inhibits new fetches while high
- vec_wr_en  in  1  vector memory write enable
- vec_wr_addr  in  ID_WIDTH  write address
- vec_wr_data  in  VAL_WIDTH  write data
- fetch_count  out  32  total ids consumed since reset

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values:
  - id_read = 0;
  - val_empty = all ones;
  - val = 0;
  - fetch_count = 0;
  - all occupancy counters and in-flight flags cleared.
  - Vector memory contents are not reset.
- Vector memory:
  - Conceptually one 2**ID_WIDTH x VAL_WIDTH array with CHANNELS read ports and 1 write port; it may be implemented as replicated copies.
  - Writes happen at the clk edge whenever vec_wr_en = 1, regardless of vec_load.
  - A read and a write to the same address in the same cycle return the old data (read-first).
- Issue (combinational, per channel c):
  - id_read[c] = !rst & !vec_load & !id_empty[c] & (occ[c] + inflight[c] < OUT_DEPTH).
  - occ and inflight are the registered values; a val_read in the same cycle does not create credit until the next cycle.
- Pipeline:
  - Cycle T: id_read[c] = 1; id[c] is sampled at the end of T.
  - End of T: memory data is registered and inflight[c] is set.
  - End of T+1: data is pushed into output FIFO c.
  - Cycle T+2: val_empty[c] = 0.
  - Id-to-value latency is 2 cycles; throughput is 1 value per cycle per channel.
- Output FIFO:
  - FWFT: val[c] shows the head whenever val_empty[c] = 0, and 0 when empty.
  - val_read[c] while empty is ignored, with no underflow.
  - A simultaneous push and pop leaves occ unchanged.
  - Overflow is impossible by construction of the credit rule. The bench must assert this.
- Ordering: strictly in order within a channel; channels are fully independent.
- vec_load rising:
  - blocks new issue in the same cycle;
  - in-flight reads complete and are pushed normally.
- fetch_count:
  - adds popcount(id_read) each cycle;
  - wraps modulo 2**32.
- Reset mid-operation: all queued and in-flight values are discarded; the state next cycle equals the reset state.

Decomposition:
- Shared constants include file: default CHANNELS/ID_WIDTH/VAL_WIDTH/OUT_DEPTH, and the occupancy width clog2(OUT_DEPTH+1).
- One natural sub-module, gather_out_fifo (parametrised VAL_WIDTH, OUT_DEPTH, FWFT, exposes occupancy), instantiated CHANNELS times via generate.
- Vector memory, issue logic and counter are kept in the top level.

Test Plan:
- Reset: hold rst 3 cycles with id_empty = 4'h0 -> id_read = 0, val_empty = 4'hF, val = 0, fetch_count = 0 throughout and 1 cycle after.
- Single fetch: load mem[i] = i[7:0]^8'hA5 for all i, then vec_load = 0, id[9:0] = 5, id_empty = 4'b1110 for one cycle -> id_read = 4'b0001 that cycle, val_empty[0] = 0 two cycles later, val[7:0] = 8'hA0, fetch_count = 1.
- Backpressure: all channels with continuous ids and val_read = 0 -> exactly 4 id_read pulses per channel, then none; val_empty = 0; fetch_count = 16; no overflow.
- Drain/stream: from the full state set val_read = 4'hF -> 1 pop per cycle per channel, and the id_read stream resumes one cycle after the first pop. Values match the scoreboard in order for 200 cycles, with no bubble once steady.
- Load mode and hazard:
  - vec_load = 1 mid-stream -> id_read = 0 the same cycle, and the one in-flight value per channel still arrives.
  - A write to addr 7 in the same cycle channel 1 issues id 7 -> channel 1 receives the old value; the next fetch of 7 returns the new value.
- Reset mid-operation: assert rst with FIFOs full and reads in flight -> val_empty = 4'hF and fetch_count = 0 on the next cycle, and no stale value appears after reset release.
